exec_sequencer: RTL and testbench
=================================

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 SHALL have port clock  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port run  input  1  level; 1 = execute instructions, 0 = stop at the next instruction boundary.
REQ-004 SHALL have port opcode  input  4  opcode field of the instruction register; valid from DECODE onward.
REQ-005 SHALL have port br_cond  input  2  branch subtype: 00 BRE, 01 BRNE, 10 BRG, 11 BRGE.
REQ-006 SHALL have port flag_reg  input  4  registered flags: [0] carry, [1] negative, [2] overflow, [3] zero.
REQ-007 SHALL have port mem_ready  input  1  data-memory completion handshake.
REQ-008 SHALL have outputs ir_load, pc_inc, pc_branch, c14, reg_we, mem_req, mem_we  output  1 each  datapath strobes; c14 is the flags-register write enable.
REQ-009 SHALL have port state  output  2  00 IDLE, 01 FETCH, 10 DECODE, 11 EXEC.
REQ-010 SHALL have port retired  output  16  count of completed instructions.

Function
REQ-011 SHALL use a 4-state FSM: IDLE -> FETCH when run=1; FETCH -> DECODE unconditionally; DECODE -> EXEC unconditionally; EXEC -> FETCH (run=1) or IDLE (run=0) on completion.
REQ-012 SHALL stay in IDLE while run=0; no strobe asserts in IDLE.
REQ-013 SHALL assert ir_load for exactly the FETCH cycle.
REQ-014 SHALL assert no strobe in DECODE.
REQ-015 SHALL complete EXEC in one cycle for every opcode except memory ops (1000 LOAD, 1001 LOADF, 1010 STORE, 1011 STOREF).
REQ-016 SHALL, for memory ops, hold EXEC with mem_req=1 until mem_ready=1; completion is the cycle mem_ready=1 is sampled.
REQ-017 SHALL assert mem_we with mem_req for STORE/STOREF only; reg_we on the completion cycle for LOAD/LOADF.
REQ-018 SHALL assert reg_we in EXEC for 0001, 0010, 0011, 0100-0111, 1100; not for 1101 CMP.
REQ-019 SHALL assert c14 in EXEC for ADD 0100, ADDI 0101, SUB 0110, SUBI 0111, SHIFT 1100, CMP 1101, only; exactly one cycle per instruction.
REQ-020 SHALL evaluate branch (1111): taken = BRE Z; BRNE !Z; BRG !Z & (N==O); BRGE (N==O), using flag_reg sampled in EXEC.
REQ-021 SHALL assert pc_branch for JUMP 1110 and taken BRANCH; pc_inc otherwise; exactly one of the two, on the EXEC completion cycle only.
REQ-022 SHALL treat NOOP 0000 as single-cycle EXEC with pc_inc only.
REQ-023 SHALL assert all strobes combinationally from state, opcode, br_cond, flag_reg, mem_ready; state is registered.
REQ-024 SHALL increment retired on each EXEC completion, saturating at 16'hFFFF.
REQ-025 SHALL sample run only at the EXEC completion edge and in IDLE; run=0 mid-instruction does not abort.
REQ-026 SHALL keep mem_req asserted while waiting even if run drops.

Reset
REQ-027 SHALL force state=IDLE, retired=0, all strobes 0 while reset=1, regardless of clock.
REQ-028 SHALL abandon any in-flight instruction (including pending memory wait) on reset with no further strobes.
REQ-029 SHALL leave IDLE no earlier than the first rising edge after reset deasserts with run=1.

Verification
REQ-030 SHALL cover: reset, run=1, opcode=0100 -> states FETCH,DECODE,EXEC; ir_load cycle 1; c14=1, reg_we=1, pc_inc=1 in EXEC; retired=1.
REQ-031 SHALL cover: LOAD with mem_ready low 3 cycles -> EXEC held 4 cycles, mem_req=1 throughout, reg_we and pc_inc only in 4th; retired increments once.
REQ-032 SHALL cover: BRANCH with flag_reg=4'b0000 for each br_cond -> pc_branch = 0,1,1,1; flag_reg=4'b1000 -> 1,0,0,1; flag_reg=4'b0010 -> 0,1,0,0.
REQ-033 SHALL cover: run dropped during DECODE of CMP -> CMP completes (c14=1, reg_we=0), FSM enters IDLE, no ir_load.
REQ-034 SHALL cover: reset asserted mid-EXEC of STORE while waiting -> mem_req, mem_we drop immediately; state=IDLE; retired=0.
REQ-035 SHALL cover: retired preloaded near saturation via 65536+ instructions -> holds 16'hFFFF, no wrap.

Source files
------------

// File: rtl/exec_sequencer.sv
// exec_sequencer: four-state instruction sequencer (IDLE/FETCH/DECODE/EXEC).
// Steps one instruction at a time and raises the datapath strobes for the
// current opcode. It also keeps a saturating count of retired instructions.
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   asynchronous, active-high; returns to IDLE and clears retired
//   run        in   level; 1 = keep executing, 0 = stop at the next boundary
//   opcode     in   [3:0] instruction opcode, valid from DECODE onward
//   br_cond    in   [1:0] branch subtype: 00 BRE, 01 BRNE, 10 BRG, 11 BRGE
//   flag_reg   in   [3:0] flags: [0] carry, [1] negative, [2] overflow, [3] zero
//   mem_ready  in   data-memory completion handshake
//   ir_load    out  instruction-register load (FETCH)
//   pc_inc     out  PC increment (EXEC completion, no branch)
//   pc_branch  out  PC load from branch target (EXEC completion, jump/taken)
//   c14        out  flags-register write enable
//   reg_we     out  register-file write enable
//   mem_req    out  data-memory request
//   mem_we     out  data-memory write
//   state      out  [1:0] 00 IDLE, 01 FETCH, 10 DECODE, 11 EXEC (registered)
//   retired    out  [15:0] completed-instruction count, saturating (registered)
//
// The strobes are combinational from state and the instruction inputs, so the
// datapath sees them in the same cycle. An asynchronous reset forces state to
// IDLE, and in IDLE every strobe is low.
module exec_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [3:0]  opcode,
  input  logic [1:0]  br_cond,
  input  logic [3:0]  flag_reg,
  input  logic        mem_ready,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        pc_branch,
  output logic        c14,
  output logic        reg_we,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  state,
  output logic [15:0] retired
);

  localparam int unsigned STATE_W   = 2;
  localparam int unsigned OPCODE_W  = 4;
  localparam int unsigned RETIRED_W = 16;

  localparam logic [OPCODE_W-1:0]  OP_SHIFT   = 4'b1100;
  localparam logic [OPCODE_W-1:0]  OP_CMP     = 4'b1101;
  localparam logic [OPCODE_W-1:0]  OP_JUMP    = 4'b1110;
  localparam logic [OPCODE_W-1:0]  OP_BRANCH  = 4'b1111;
  localparam logic [RETIRED_W-1:0] RETIRED_MAX = '1;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'b00,
    FETCH  = 2'b01,
    DECODE = 2'b10,
    EXEC   = 2'b11
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   exec_done;

  // Opcode classification.
  logic is_mem;
  logic is_load;
  logic is_store;
  logic is_alu_wr;
  logic is_flag_wr;
  logic is_jump;
  logic is_branch;

  // Memory ops occupy 10xx: bit 1 selects STORE/STOREF over LOAD/LOADF.
  assign is_mem     = (opcode[3:2] == 2'b10);
  assign is_store   = is_mem &  opcode[1];
  assign is_load    = is_mem & ~opcode[1];
  // 0001..0111 and SHIFT write a register; CMP only updates flags.
  assign is_alu_wr  = ((opcode[3] == 1'b0) && (opcode != 4'b0000)) || (opcode == OP_SHIFT);
  assign is_flag_wr = (opcode[3:2] == 2'b01) || (opcode == OP_SHIFT) || (opcode == OP_CMP);
  assign is_jump    = (opcode == OP_JUMP);
  assign is_branch  = (opcode == OP_BRANCH);

  // Branch condition evaluated on the live flag register.
  logic flag_neg;
  logic flag_ovf;
  logic flag_zero;
  logic unused_carry;
  logic br_taken;

  assign flag_neg     = flag_reg[1];
  assign flag_ovf     = flag_reg[2];
  assign flag_zero    = flag_reg[3];
  assign unused_carry = flag_reg[0];

  always_comb begin
    br_taken = 1'b0;
    case (br_cond)
      2'b00:   br_taken = flag_zero;
      2'b01:   br_taken = ~flag_zero;
      2'b10:   br_taken = ~flag_zero & (flag_neg == flag_ovf);
      default: br_taken = (flag_neg == flag_ovf);
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and strobes.
  always_comb begin
    state_d   = state_q;
    exec_done = 1'b0;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_branch = 1'b0;
    c14       = 1'b0;
    reg_we    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;

    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        ir_load = 1'b1;
        state_d = DECODE;
      end

      DECODE: begin
        state_d = EXEC;
      end

      EXEC: begin
        // Memory ops hold EXEC with the request up until the handshake.
        if (is_mem) begin
          mem_req   = 1'b1;
          mem_we    = is_store;
          exec_done = mem_ready;
        end else begin
          exec_done = 1'b1;
        end

        // Run is only looked at here, so dropping it mid-instruction never aborts.
        if (exec_done) begin
          reg_we    = is_load | is_alu_wr;
          c14       = is_flag_wr;
          pc_branch = is_jump | (is_branch & br_taken);
          pc_inc    = ~pc_branch;
          state_d   = run ? FETCH : IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign state = STATE_W'(state_q);

  // Retired-instruction counter, saturating rather than wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retired <= '0;
    end else if (exec_done && (retired != RETIRED_MAX)) begin
      retired <= retired + RETIRED_W'(1);
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer. Each issued instruction pushes its
// expected completion-cycle strobes and pre-completion retired count to a
// scoreboard. A negedge monitor pops and compares an entry on every
// completion (pc_inc or pc_branch high).
module tb_exec_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic [3:0]  opcode;
  logic [1:0]  br_cond;
  logic [3:0]  flag_reg;
  logic        mem_ready;
  logic        ir_load, pc_inc, pc_branch, c14, reg_we, mem_req, mem_we;
  logic [1:0]  state;
  logic [15:0] retired;
  logic [6:0]  obs;

  int errors = 0;
  int checks = 0;
  int model_retired = 0;

  typedef struct {
    logic [6:0]  strobes;
    logic [15:0] retired_before;
  } exp_t;

  exp_t sb[$];

  exec_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .opcode    (opcode),
    .br_cond   (br_cond),
    .flag_reg  (flag_reg),
    .mem_ready (mem_ready),
    .ir_load   (ir_load),
    .pc_inc    (pc_inc),
    .pc_branch (pc_branch),
    .c14       (c14),
    .reg_we    (reg_we),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .state     (state),
    .retired   (retired)
  );

  always #5 clock = ~clock;

  // {ir_load, pc_inc, pc_branch, c14, reg_we, mem_req, mem_we}
  assign obs = {ir_load, pc_inc, pc_branch, c14, reg_we, mem_req, mem_we};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference for the completion-cycle strobe vector.
  function automatic logic [6:0] model(input logic [3:0] op, input logic [1:0] brc,
                                       input logic [3:0] fl);
    logic z, n, o, tk, mem, we, rw, c, br;
    z = fl[3];
    n = fl[1];
    o = fl[2];
    case (brc)
      2'd0:    tk = z;
      2'd1:    tk = !z;
      2'd2:    tk = !z && (n == o);
      default: tk = (n == o);
    endcase
    mem = op inside {[4'd8:4'd11]};
    we  = op inside {4'd10, 4'd11};
    rw  = op inside {[4'd1:4'd7], 4'd8, 4'd9, 4'd12};
    c   = op inside {[4'd4:4'd7], 4'd12, 4'd13};
    br  = (op == 4'd14) || ((op == 4'd15) && tk);
    return {1'b0, !br, br, c, rw, mem, we};
  endfunction

  task automatic push(input logic [6:0] s);
    exp_t e;
    e.strobes        = s;
    e.retired_before = 16'(model_retired);
    sb.push_back(e);
    if (model_retired < 65535) model_retired++;
  endtask

  // Scoreboard consumer: one entry per EXEC completion.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && (pc_inc || pc_branch)) begin
      check("completion_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("completion_strobes", 32'(obs), 32'(e.strobes));
        check("retired_before", 32'(retired), 32'(e.retired_before));
      end
    end
  end

  // Entered just after the edge that put the DUT in FETCH.
  task automatic instr(input logic [3:0] op, input logic [1:0] brc, input logic [3:0] fl,
                       input int waits, input logic drop_run, input logic [6:0] exp);
    opcode    = op;
    br_cond   = brc;
    flag_reg  = fl;
    mem_ready = 1'b0;
    push(exp);
    @(negedge clock);
    check("fetch_state", 32'(state), 1);
    check("fetch_strobes", 32'(obs), 32'h40);
    @(posedge clock); #1;
    if (drop_run) run = 1'b0;
    @(negedge clock);
    check("decode_state", 32'(state), 2);
    check("decode_strobes", 32'(obs), 0);
    @(posedge clock); #1;
    for (int i = 0; i < waits; i++) begin
      @(negedge clock);
      check("exec_wait_state", 32'(state), 3);
      check("exec_wait_strobes", 32'(obs), 32'({5'b0, 1'b1, exp[0]}));
      @(posedge clock); #1;
    end
    mem_ready = 1'b1;
    @(negedge clock);
    check("exec_state", 32'(state), 3);
    @(posedge clock); #1;
    mem_ready = 1'b0;
  endtask

  logic [3:0] alu_ops [10];
  logic [3:0] br_flags [3];
  logic [3:0] taken_tab [3];
  logic       tk;
  int         cyc;

  initial begin
    alu_ops   = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd12, 4'd13, 4'd14};
    br_flags  = '{4'b0000, 4'b1000, 4'b0010};
    // bit index = br_cond
    taken_tab = '{4'b1110, 4'b1001, 4'b0010};

    reset = 1'b1; run = 1'b0; opcode = '0; br_cond = '0; flag_reg = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", 32'(state), 0);
    check("reset_strobes", 32'(obs), 0);
    check("reset_retired", 32'(retired), 0);
    run = 1'b1;
    @(posedge clock); #1;
    check("reset_hold_state", 32'(state), 0);

    // Released with run low: stays in IDLE with nothing asserted.
    @(negedge clock);
    reset = 1'b0;
    run   = 1'b0;
    @(posedge clock); #1;
    check("idle_state", 32'(state), 0);
    @(negedge clock);
    check("idle_strobes", 32'(obs), 0);
    run = 1'b1;
    @(posedge clock); #1;

    // ADD, then retired must read 1.
    instr(4'd4, 2'd0, 4'd0, 0, 1'b0, model(4'd4, 2'd0, 4'd0));
    check("retired_after_add", 32'(retired), 1);

    // Single-cycle opcodes.
    foreach (alu_ops[i]) instr(alu_ops[i], 2'd0, 4'd0, 0, 1'b0, model(alu_ops[i], 2'd0, 4'd0));

    // Memory ops: LOAD held three extra cycles, others varied.
    instr(4'd8,  2'd0, 4'd0, 3, 1'b0, model(4'd8,  2'd0, 4'd0));
    instr(4'd9,  2'd0, 4'd0, 0, 1'b0, model(4'd9,  2'd0, 4'd0));
    instr(4'd10, 2'd0, 4'd0, 2, 1'b0, model(4'd10, 2'd0, 4'd0));
    instr(4'd11, 2'd0, 4'd0, 1, 1'b0, model(4'd11, 2'd0, 4'd0));

    // Branch condition table.
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < 4; c++) begin
        tk = taken_tab[f][c];
        instr(4'd15, 2'(c), br_flags[f], 0, 1'b0, {1'b0, !tk, tk, 4'b0000});
      end
    end

    // CMP with run dropped in DECODE: completes, then parks in IDLE.
    instr(4'd13, 2'd0, 4'd0, 0, 1'b1, model(4'd13, 2'd0, 4'd0));
    @(negedge clock);
    check("cmp_stop_state", 32'(state), 0);
    check("cmp_stop_ir_load", 32'(ir_load), 0);
    @(negedge clock);
    check("cmp_stop_state2", 32'(state), 0);

    // STORE with reset landing mid-cycle while waiting on memory.
    run = 1'b1;
    opcode = 4'd10;
    mem_ready = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(negedge clock);
    check("store_wait_state", 32'(state), 3);
    check("store_wait_strobes", 32'(obs), 32'h03);
    check("store_retired_nonzero", 32'(retired != 0), 1);
    #2;
    reset = 1'b1;
    #1;
    check("abort_strobes", 32'(obs), 0);
    check("abort_state", 32'(state), 0);
    check("abort_retired", 32'(retired), 0);
    sb.delete();
    model_retired = 0;
    @(posedge clock); #1;
    check("abort_hold_state", 32'(state), 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("release_state", 32'(state), 0);
    @(posedge clock); #1;
    check("release_fetch_state", 32'(state), 1);

    // Saturation: a long NOOP stream past 65535 completions.
    opcode = 4'd0;
    for (int i = 0; i < 65538; i++) push(7'b0100000);
    cyc = 0;
    while (!(sb.size() == 1 && state == 2'd2) && cyc < 250000) begin
      @(negedge clock);
      cyc++;
    end
    check("sat_within_bound", 32'(cyc < 250000), 1);
    run = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(negedge clock);
    check("sat_state", 32'(state), 0);
    check("sat_retired", 32'(retired), 32'hFFFF);
    check("scoreboard_drained", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
